// File: rtl/pwm_compare8.sv
// -----------------------------------------------------------------------------
// pwm_compare8
//
// PWM generator that follows an external 8-bit free-running counter. Each cycle
// it compares the sampled counter value against the active duty threshold and
// produces a registered PWM output. A new duty value is written into a shadow
// register through a valid/ready handshake. It only becomes active at a true
// counter wrap (255 -> 0), so every PWM period is glitch-free.
//
// Ports
//   clk           rising-edge clock, shared with the counter stage
//   reset         asynchronous, active-high reset
//   cnt           current counter value from the counter stage
//   enable        1 = PWM runs, 0 = pwm_out forced low
//                 (handshake and duty updates keep running)
//   duty_in       requested duty: high counts per 256-count period
//   duty_valid    duty_in is valid this cycle
//   duty_ready    shadow register can accept a write (= ~pending)
//   pwm_out       registered PWM output, high while cnt < duty
//   period_start  one-cycle pulse, registered, marking count 0 of a new period
//   update_done   one-cycle pulse, registered, when the shadow duty goes active
// -----------------------------------------------------------------------------
module pwm_compare8 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] cnt,
    input  logic             enable,
    input  logic [WIDTH-1:0] duty_in,
    input  logic             duty_valid,
    output logic             duty_ready,
    output logic             pwm_out,
    output logic             period_start,
    output logic             update_done
);

    logic [WIDTH-1:0] prev_cnt;
    logic [WIDTH-1:0] shadow;
    logic             pending;
    logic [WIDTH-1:0] active;

    logic             wrap;
    logic             apply;
    logic             accept;
    logic [WIDTH-1:0] eff;

    // Only a real terminal-count rollover counts as a boundary. A counter that
    // is cleared mid-period also lands on 0, but its previous value is not
    // all-ones, so the active duty stays put.
    assign wrap   = (cnt == '0) && (prev_cnt == '1);
    assign apply  = wrap && pending;

    // The shadow can only be written while it holds no unapplied value.
    // Because accept needs !pending and apply needs pending, the two never
    // happen in the same cycle. A write that lands on a wrap with nothing
    // pending is therefore held until the following wrap.
    assign accept = duty_valid && !pending;

    // When applying, the new duty already governs count 0 of the new period.
    assign eff    = apply ? shadow : active;

    assign duty_ready = ~pending;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_cnt     <= '0;
            shadow       <= '0;
            pending      <= 1'b0;
            active       <= '0;
            pwm_out      <= 1'b0;
            period_start <= 1'b0;
            update_done  <= 1'b0;
        end else begin
            prev_cnt     <= cnt;
            period_start <= wrap;
            update_done  <= apply;
            // Plain unsigned compare: duty 0 is never high, and duty 255 is
            // high for 255 of 256 counts. 100 % high is not reachable.
            pwm_out      <= enable && (cnt < eff);

            if (apply) begin
                active  <= shadow;
                pending <= 1'b0;
            end else if (accept) begin
                shadow  <= duty_in;
                pending <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pwm_compare8.sv
module tb_pwm_compare8;

    logic       clk;
    logic       reset;
    logic [7:0] cnt;
    logic       enable;
    logic [7:0] duty_in;
    logic       duty_valid;
    logic       duty_ready;
    logic       pwm_out;
    logic       period_start;
    logic       update_done;

    int vectors    = 0;
    int miscompares = 0;

    // Reference model: what the block should be doing, from the behaviour rules.
    logic [7:0] m_prev;
    logic [7:0] m_shadow;
    logic       m_pending;
    logic [7:0] m_active;
    logic       e_pwm, e_ps, e_ud;
    logic       last_acc;

    pwm_compare8 #(.WIDTH(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .cnt          (cnt),
        .enable       (enable),
        .duty_in      (duty_in),
        .duty_valid   (duty_valid),
        .duty_ready   (duty_ready),
        .pwm_out      (pwm_out),
        .period_start (period_start),
        .update_done  (update_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        m_prev    = 8'h00;
        m_shadow  = 8'h00;
        m_pending = 1'b0;
        m_active  = 8'h00;
    endtask

    // One clock: predict, clock, compare all outputs, then advance the counter.
    // The source drops duty_valid once its write has been taken.
    task automatic tick();
        logic       wrap, app, acc;
        logic [7:0] d_use;
        logic [3:0] exp_v, got_v;
        wrap  = (cnt == 8'h00) && (m_prev == 8'hFF);
        app   = wrap && m_pending;
        acc   = duty_valid && !m_pending;
        d_use = app ? m_shadow : m_active;
        e_pwm = enable && (cnt < d_use);
        e_ps  = wrap;
        e_ud  = app;
        if (app) begin
            m_active  = m_shadow;
            m_pending = 1'b0;
        end
        if (acc) begin
            m_shadow  = duty_in;
            m_pending = 1'b1;
        end
        m_prev   = cnt;
        last_acc = acc;
        @(posedge clk);
        #1;
        exp_v = {e_pwm, e_ps, e_ud, !m_pending};
        got_v = {pwm_out, period_start, update_done, duty_ready};
        vectors++;
        if (got_v !== exp_v) begin
            miscompares++;
            $display("FAIL cycle_outputs cnt_sampled=%02h {pwm,ps,ud,rdy} got %b exp %b",
                     m_prev, got_v, exp_v);
        end
        if (acc) duty_valid = 1'b0;
        cnt = cnt + 8'd1;
    endtask

    task automatic advance_to(input logic [7:0] v);
        int n = 0;
        while (cnt != v && n < 600) begin
            tick();
            n++;
        end
        vectors++;
        if (cnt != v) begin
            miscompares++;
            $display("FAIL advance_to got cnt %02h exp %02h", cnt, v);
        end
    endtask

    task automatic do_write(input logic [7:0] d);
        int n = 0;
        duty_in    = d;
        duty_valid = 1'b1;
        do begin
            tick();
            n++;
        end while (!last_acc && n < 600);
        vectors++;
        if (!last_acc) begin
            miscompares++;
            $display("FAIL write_accept duty %02h got accepted 0 exp 1", d);
            duty_valid = 1'b0;
        end
    endtask

    // Waits for the next period start, then counts high cycles over 256 counts.
    task automatic measure_period(output int hi, output logic last_pwm);
        int n = 0;
        hi = 0;
        do begin
            tick();
            n++;
        end while (!period_start && n < 600);
        vectors++;
        if (!period_start) begin
            miscompares++;
            $display("FAIL measure_period got period_start 0 exp 1");
        end
        hi = int'(pwm_out);
        repeat (255) begin
            tick();
            hi += int'(pwm_out);
        end
        last_pwm = pwm_out;
    endtask

    task automatic test_reset();
        int   hi;
        logic lp;
        logic was_high;
        reset      = 1'b1;
        enable     = 1'b1;
        cnt        = 8'h00;
        duty_in    = 8'h00;
        duty_valid = 1'b0;
        model_reset();
        #12 reset = 1'b0;
        do_write(8'hFF);
        measure_period(hi, lp);
        advance_to(8'h80);
        was_high = pwm_out;
        #3 reset = 1'b1;
        #1;
        vectors++;
        if (!was_high || {pwm_out, period_start, update_done, duty_ready} !== 4'b0001) begin
            miscompares++;
            $display("FAIL reset_async pre_pwm %b {pwm,ps,ud,rdy} got %b exp 0001",
                     was_high, {pwm_out, period_start, update_done, duty_ready});
        end
        #1 reset = 1'b0;
        model_reset();
        hi = 0;
        while (cnt != 8'h01) begin
            tick();
            hi += int'(pwm_out);
        end
        vectors++;
        if (hi != 0) begin
            miscompares++;
            $display("FAIL reset_first_period pwm highs got %0d exp 0", hi);
        end
    endtask

    task automatic test_basic();
        int   hi;
        logic lp;
        advance_to(8'h10);
        do_write(8'h40);
        vectors++;
        if (duty_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_ready_drop got %b exp 0", duty_ready);
        end
        while (!period_start && cnt != 8'h05) tick();
        vectors++;
        if ({period_start, update_done} !== 2'b11) begin
            miscompares++;
            $display("FAIL basic_wrap {ps,ud} got %b exp 11", {period_start, update_done});
        end
        tick();
        vectors++;
        if (duty_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL basic_ready_rise got %b exp 1", duty_ready);
        end
        measure_period(hi, lp);
        vectors++;
        if (hi != 64) begin
            miscompares++;
            $display("FAIL basic_duty_0x40 highs got %0d exp 64", hi);
        end
    endtask

    task automatic test_extremes();
        int   hi;
        logic lp;
        do_write(8'h00);
        measure_period(hi, lp);
        vectors++;
        if (hi != 0) begin
            miscompares++;
            $display("FAIL duty_0x00 highs got %0d exp 0", hi);
        end
        do_write(8'hFF);
        measure_period(hi, lp);
        vectors++;
        if (hi != 255 || lp !== 1'b0) begin
            miscompares++;
            $display("FAIL duty_0xFF highs/last got %0d/%b exp 255/0", hi, lp);
        end
    endtask

    task automatic test_wrap_accept();
        int n;
        int hi;
        advance_to(8'h00);
        duty_in    = 8'h30;
        duty_valid = 1'b1;
        tick();
        vectors++;
        if ({last_acc, period_start, update_done} !== 3'b110) begin
            miscompares++;
            $display("FAIL wrap_accept {acc,ps,ud} got %b exp 110",
                     {last_acc, period_start, update_done});
        end
        n = 0;
        do begin
            tick();
            n++;
        end while (!update_done && n < 600);
        vectors++;
        if (n != 256) begin
            miscompares++;
            $display("FAIL wrap_accept_delay cycles got %0d exp 256", n);
        end
        hi = int'(pwm_out);
        repeat (255) begin
            tick();
            hi += int'(pwm_out);
        end
        vectors++;
        if (hi != 48) begin
            miscompares++;
            $display("FAIL wrap_accept_duty highs got %0d exp 48", hi);
        end
    endtask

    task automatic test_back_to_back();
        int   hi1, hi2;
        logic lp;
        advance_to(8'h50);
        do_write(8'h20);
        duty_in    = 8'h90;
        duty_valid = 1'b1;
        tick();
        vectors++;
        if (last_acc !== 1'b0) begin
            miscompares++;
            $display("FAIL hold_not_ready accepted got %b exp 0", last_acc);
        end
        measure_period(hi1, lp);
        measure_period(hi2, lp);
        vectors++;
        if (hi1 != 32 || hi2 != 144) begin
            miscompares++;
            $display("FAIL back_to_back highs got %0d,%0d exp 32,144", hi1, hi2);
        end
    endtask

    task automatic test_cnt_reset_enable();
        int   hi;
        logic lp;
        advance_to(8'h20);
        do_write(8'h70);
        advance_to(8'h37);
        tick();
        cnt = 8'h00;
        tick();
        vectors++;
        if ({period_start, update_done, duty_ready} !== 3'b000) begin
            miscompares++;
            $display("FAIL cnt_clear_no_wrap {ps,ud,rdy} got %b exp 000",
                     {period_start, update_done, duty_ready});
        end
        measure_period(hi, lp);
        vectors++;
        if (hi != 112) begin
            miscompares++;
            $display("FAIL cnt_clear_apply highs got %0d exp 112", hi);
        end
        advance_to(8'h10);
        enable = 1'b0;
        tick();
        vectors++;
        if (pwm_out !== 1'b0) begin
            miscompares++;
            $display("FAIL enable_mask pwm got %b exp 0", pwm_out);
        end
        while (cnt != 8'h00) tick();
        tick();
        vectors++;
        if ({period_start, pwm_out} !== 2'b10) begin
            miscompares++;
            $display("FAIL enable_off_wrap {ps,pwm} got %b exp 10", {period_start, pwm_out});
        end
        enable = 1'b1;
    endtask

    task automatic test_random();
        repeat (3000) begin
            if (!duty_valid && $urandom_range(0, 99) < 3) begin
                duty_valid = 1'b1;
                duty_in    = 8'($urandom_range(0, 255));
            end
            if ($urandom_range(0, 199) == 0) enable = ~enable;
            tick();
            if ($urandom_range(0, 499) == 0) cnt = 8'h00;
        end
        enable = 1'b1;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_extremes();
        test_wrap_accept();
        test_back_to_back();
        test_cnt_reset_enable();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pwm_compare8.md
# pwm_compare8

Downstream consumer of the 8-bit free-running counter. It samples the counter value each cycle and generates a registered PWM output whose duty is the count threshold. New duty values arrive through a valid/ready handshake and are double-buffered, so they only take effect at a counter wrap (255 -> 0). This keeps every PWM period glitch-free. It also emits a one-cycle period-start pulse and an update-acknowledge pulse for the control logic.

## Interface
- WIDTH, 8, width of counter value and duty; all behaviour below is stated for 8
- clk  input  1  rising-edge clock, same clock as the counter
- reset  input  1  reset, asynchronous, active-high
- cnt  input  8  current counter value from the counter stage
- enable  input  1  1 = PWM runs; 0 = pwm_out forced low
- duty_in  input  8  requested duty (high counts per 256-count period)
- duty_valid  input  1  duty_in is valid this cycle
- duty_ready  output  1  shadow register can accept a duty write
- pwm_out  output  1  registered PWM output
- period_start  output  1  one-cycle pulse marking a new period
- update_done  output  1  one-cycle pulse when the shadow duty becomes active

## Operation
- Internal registers:
  - prev_cnt[7:0]: cnt from the previous cycle
  - shadow[7:0]: buffered duty
  - pending: shadow holds an unapplied write
  - active[7:0]: duty in use
- Reset values:
  - prev_cnt=0, shadow=0, pending=0, active=0
  - pwm_out=0, period_start=0, update_done=0
  - duty_ready=1, driven as ~pending
- Boundary: wrap = (cnt==8'h00) && (prev_cnt==8'hFF), evaluated combinationally in the current cycle.
- A cnt jump that is not 255->0 is not a boundary (e.g. counter reset mid-period: cnt goes to 0 from 0x37). active stays unchanged.
- Handshake:
  - A write is accepted when duty_valid && duty_ready, giving shadow<=duty_in, pending<=1.
  - duty_valid while not ready is ignored; the source holds it.
- Apply on wrap with pending=1: active<=shadow, pending<=0, update_done<=1 for one cycle.
- Same-cycle accept and wrap with pending=0: the write is captured into shadow but not applied on this wrap. It applies on the next wrap.
- Compare value eff = (wrap && pending) ? shadow : active, so the new duty governs count 0 of the new period.
- pwm_out <= enable && (cnt < eff). Unsigned compare, no arithmetic overflow:
  - duty 0: always low
  - duty 255: high 255 of 256 counts
  - 100% high is not reachable by design
- period_start <= wrap.
- enable=0 does not stall the handshake or apply logic; only pwm_out is masked.

## Timing
- pwm_out, period_start and update_done each have 1-cycle latency: they reflect the cnt sampled at the previous edge.
- period_start and the pwm_out for cnt=0 appear on the same cycle.
- update_done coincides with period_start when a pending update is applied.
- duty_ready:
  - drops the cycle after an accept
  - rises the cycle after the applying wrap
  - so the minimum spacing between accepted writes is one period
- Asynchronous reset mid-period clears all registers immediately:
  - a pending write is discarded and active returns to 0
  - pwm_out is 0 until released and the next compare
- After reset release with the counter also released, the first wrap occurs when cnt goes 255->0. Before that, active=0, so pwm_out stays 0.

## Test plan
- Reset with counter running at cnt=0x80 -> all outputs 0 and duty_ready=1 immediately; pwm_out stays 0 for the whole first period.
- Write duty 0x40 at cnt=0x10 with enable=1 -> duty_ready=0 next cycle; at the wrap, period_start=update_done=1 together; pwm_out high for exactly 64 cycles per period thereafter; duty_ready=1 after the wrap.
- Write 0x00 and separately 0xFF -> 0x00: pwm_out never high; 0xFF: pwm_out high 255 cycles, low 1 cycle (the one reflecting cnt=0xFF).
- Write accepted on the wrap cycle itself with pending=0 -> no update_done at that wrap; the new duty applies and update_done pulses one full period (256 cycles) later.
- Hold duty_valid with 0x20, then 0x90 while pending -> second value not accepted until duty_ready returns; periods show 0x20, then 0x90 the following period.
- Counter reset to 0 mid-period at cnt=0x37 with a write pending -> no period_start, no update_done; update applies only at the next true 255->0 wrap. Toggle enable=0 mid-period -> pwm_out 0 one cycle later, period_start still pulses.
